mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- Sole owner of the byte-serial RAM port, shared between the instruction fetcher and the load/store buffer.
- Arbitrates the two requesters, sequences 1/2/4-byte reads and writes one byte per cycle, assembles and sign/zero-extends load data, and stalls IO writes while the IO buffer is full.
- Sits between the fetch unit, the load/store buffer and the top-level RAM/IO interface.

Parameters:
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO-mapped; writes to them obey io_buffer_full.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset. Asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes the block.
- rob_clear_up  in  1  misprediction flush.
- mem_din  in  8  RAM read byte; valid the cycle after its address is driven.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  IO write buffer full.
- if_req  in  1  fetch request; held with if_addr until if_accept.
- if_addr  in  32  fetch address (4-byte read).
- if_accept  out  1  one-cycle pulse: fetch request latched.
- if_ready  out  1  one-cycle pulse: if_data valid.
- if_data  out  32  fetched instruction, little-endian.
- ls_req  in  1  LSB request; held with ls_we/ls_op/ls_addr/ls_wdata until ls_accept.
- ls_we  in  1  1 = store, 0 = load.
- ls_op  in  3  funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data; low bytes used.
- ls_accept  out  1  one-cycle pulse: LSB request latched.
- ls_ready  out  1  one-cycle pulse: access complete.
- ls_is_load  out  1  qualifies ls_ready; 1 = load.
- ls_rdata  out  32  extended load data; 0 for stores.

Behaviour:
- Reset (async, rst_n_in low): all outputs 0, state IDLE, byte counter 0, last_grant 0. Clears immediately, without a clock edge.
- rdy_in low: all registers hold; mem_wr is forced 0.
- States: IDLE, IO_WAIT, READ, WRITE.
- Byte count N comes from op[1:0]: 0→1, 1→2, 2→4. Fetch always uses N=4.
- Arbitration in IDLE:
  - Only the IDLE state samples requests.
  - If both if_req and ls_req are high, the LSB wins (fixed priority).
  - The granted request is latched and its *_accept is high for the next cycle (cycle 0).
  - The loser stays pending.
- READ:
  - mem_a = addr+k during cycle k, for k = 0..N-1. Address arithmetic wraps mod 2^32.
  - Byte k is captured from mem_din at the end of cycle k+1.
  - *_ready is high in cycle N+1 together with the data.
  - The state is IDLE in cycle N+1, so a new grant can be taken at the end of that cycle.
- Load extension:
  - B: sign-extend bit 7. H: sign-extend bit 15.
  - BU/HU: zero-extend. W: no extension.
  - ls_is_load=1 with ls_ready.
- WRITE:
  - During cycle k, mem_wr=1, mem_a=addr+k, mem_dout=wdata[8k+7:8k].
  - ls_ready is high in cycle N with ls_is_load=0. mem_wr is 0 in that cycle.
- IO stall:
  - A granted store with addr >= IO_BASE enters IO_WAIT while io_buffer_full=1; mem_wr=0 while waiting.
  - It enters WRITE on the first cycle io_buffer_full=0. Cycle 0 is then redefined as the first WRITE cycle.
- Flush (rob_clear_up=1 and rdy_in=1):
  - READ: aborts to IDLE with no *_ready.
  - IO_WAIT and WRITE: the store continues to completion and ls_ready still pulses, because stores are committed.
  - Requests presented in the flush cycle are not granted.
- mem_a keeps its last value when idle. mem_wr is 1 only in WRITE.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are high, grant the requester that did not receive the previous grant (last_grant; 0 = fetch, 1 = LSB); a single requester is always granted.
- Undefined: fixed LSB priority.

Test Plan:
1. if_req, if_addr=0x100, RAM 0x13,0x05,0x00,0x00 → if_accept in cycle 0; mem_a 0x100..0x103 in cycles 0-3; if_ready in cycle 5 with if_data=0x00000513.
2. if_req and ls_req together, LB at 0x200 where RAM=0x80 → LSB granted first; ls_rdata=0xFFFFFF80 in cycle 2; fetch granted afterwards. Repeat with LBU → 0x00000080.
3. SH at 0x1FE, ls_wdata=0xABCD1234 → mem_wr=1 with (0x1FE,0x34) then (0x1FF,0x12); ls_ready with ls_is_load=0 in cycle 2; no further writes.
4. SB at 0x30000, wdata 0x41, io_buffer_full=1 for 3 cycles → mem_wr stays 0; one write of 0x41 after release; ls_ready one cycle later.
5. rob_clear_up in cycle 2 of LW → no ls_ready, back to IDLE. rob_clear_up in cycle 1 of SW 0xDEADBEEF → bytes EF,BE,AD,DE all written; ls_ready pulses.
6. rst_n_in low mid-write → mem_wr and all outputs 0 asynchronously. With MEM_ARB_RR_EN, continuous dual requests → grants alternate LSB, fetch, LSB, ...

Source files
------------

// File: rtl/mem_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_ctrl_if
//  Description : Byte-serial RAM port, fetch request port and load/store port
//                bundled for the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_ctrl_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_accept;
  logic        if_ready;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_op;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_accept;
  logic        ls_ready;
  logic        ls_is_load;
  logic [31:0] ls_rdata;

  modport slave (
    input  mem_din, io_buffer_full, if_req, if_addr,
           ls_req, ls_we, ls_op, ls_addr, ls_wdata,
    output mem_dout, mem_a, mem_wr, if_accept, if_ready, if_data,
           ls_accept, ls_ready, ls_is_load, ls_rdata
  );

  modport master (
    output mem_din, io_buffer_full, if_req, if_addr,
           ls_req, ls_we, ls_op, ls_addr, ls_wdata,
    input  mem_dout, mem_a, mem_wr, if_accept, if_ready, if_data,
           ls_accept, ls_ready, ls_is_load, ls_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_ctrl
//  Description : Arbitrates fetch and load/store access to a byte-serial RAM,
//                sequencing 1/2/4-byte transfers. Define MEM_ARB_RR_EN for
//                round-robin arbitration instead of fixed LSB priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              rob_clear_up,
  mem_arbiter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IO_WAIT = 2'd1,
    ST_READ    = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt, r_len, w_len_nxt, r_op, w_op_nxt;
  logic [31:0] r_addr, w_addr_nxt, r_wdata, w_wdata_nxt, r_buf, w_buf_nxt;
  logic        r_is_ls, w_is_ls_nxt;
  logic [31:0] r_mem_a, w_mem_a_nxt, r_if_data, w_if_data_nxt, r_ls_rdata, w_ls_rdata_nxt;
  logic [7:0]  r_mem_dout, w_mem_dout_nxt;
  logic        r_if_accept, w_if_accept_nxt, r_ls_accept, w_ls_accept_nxt;
  logic        r_if_ready, w_if_ready_nxt, r_ls_ready, w_ls_ready_nxt;
  logic        r_ls_is_load, w_ls_is_load_nxt;

  logic        w_grant_ls, w_grant_any;
  logic [2:0]  w_ls_len, w_cnt_inc;
  logic [31:0] w_req_addr, w_addr_next, w_full, w_ext;
  logic [7:0]  w_wbyte_next;

  assign w_grant_any = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      r_last_grant <= 1'b0;
    else if (rdy_in && (r_state == ST_IDLE) && !rob_clear_up && w_grant_any)
      r_last_grant <= w_grant_ls;
  end

  assign w_grant_ls = bus.ls_req & (~bus.if_req | ~r_last_grant);
`else
  assign w_grant_ls = bus.ls_req;
`endif

  assign w_req_addr  = w_grant_ls ? bus.ls_addr : bus.if_addr;
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_addr_next = r_addr + {29'd0, w_cnt_inc};

  always_comb begin
    w_ls_len = 3'd4;
    case (bus.ls_op[1:0])
      2'd0:    w_ls_len = 3'd1;
      2'd1:    w_ls_len = 3'd2;
      default: w_ls_len = 3'd4;
    endcase
  end

  always_comb begin
    w_wbyte_next = r_wdata[7:0];
    case (w_cnt_inc)
      3'd1:    w_wbyte_next = r_wdata[15:8];
      3'd2:    w_wbyte_next = r_wdata[23:16];
      3'd3:    w_wbyte_next = r_wdata[31:24];
      default: w_wbyte_next = r_wdata[7:0];
    endcase
  end

  // mem_din carries the byte addressed in the previous cycle, i.e. byte r_cnt-1
  always_comb begin
    w_full = r_buf;
    case (r_cnt)
      3'd1:    w_full[7:0]   = bus.mem_din;
      3'd2:    w_full[15:8]  = bus.mem_din;
      3'd3:    w_full[23:16] = bus.mem_din;
      3'd4:    w_full[31:24] = bus.mem_din;
      default: w_full        = r_buf;
    endcase
  end

  always_comb begin
    w_ext = w_full;
    case (r_op)
      3'd0:    w_ext = {{24{w_full[7]}},  w_full[7:0]};
      3'd1:    w_ext = {{16{w_full[15]}}, w_full[15:0]};
      3'd4:    w_ext = {24'd0, w_full[7:0]};
      3'd5:    w_ext = {16'd0, w_full[15:0]};
      default: w_ext = w_full;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_len_nxt        = r_len;
    w_op_nxt         = r_op;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_buf_nxt        = r_buf;
    w_is_ls_nxt      = r_is_ls;
    w_mem_a_nxt      = r_mem_a;
    w_mem_dout_nxt   = r_mem_dout;
    w_if_data_nxt    = r_if_data;
    w_ls_rdata_nxt   = r_ls_rdata;
    w_if_accept_nxt  = 1'b0;
    w_ls_accept_nxt  = 1'b0;
    w_if_ready_nxt   = 1'b0;
    w_ls_ready_nxt   = 1'b0;
    w_ls_is_load_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!rob_clear_up && w_grant_any) begin
          w_cnt_nxt   = 3'd0;
          w_buf_nxt   = 32'd0;
          w_addr_nxt  = w_req_addr;
          w_mem_a_nxt = w_req_addr;
          w_is_ls_nxt = w_grant_ls;
          if (w_grant_ls) begin
            w_ls_accept_nxt = 1'b1;
            w_len_nxt       = w_ls_len;
            w_op_nxt        = bus.ls_op;
            w_wdata_nxt     = bus.ls_wdata;
            if (bus.ls_we) begin
              w_mem_dout_nxt = bus.ls_wdata[7:0];
              w_state_nxt    = ((bus.ls_addr >= IO_BASE) && bus.io_buffer_full)
                               ? ST_IO_WAIT : ST_WRITE;
            end else begin
              w_state_nxt = ST_READ;
            end
          end else begin
            w_if_accept_nxt = 1'b1;
            w_len_nxt       = 3'd4;
            w_op_nxt        = 3'd2;
            w_state_nxt     = ST_READ;
          end
        end
      end

      // Address and first byte were loaded at grant time
      ST_IO_WAIT: begin
        if (!bus.io_buffer_full)
          w_state_nxt = ST_WRITE;
      end

      ST_READ: begin
        if (rob_clear_up) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == r_len) begin
          w_state_nxt = ST_IDLE;
          if (r_is_ls) begin
            w_ls_ready_nxt   = 1'b1;
            w_ls_is_load_nxt = 1'b1;
            w_ls_rdata_nxt   = w_ext;
          end else begin
            w_if_ready_nxt = 1'b1;
            w_if_data_nxt  = w_full;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt != 3'd0)
            w_buf_nxt = w_full;
          if (w_cnt_inc != r_len)
            w_mem_a_nxt = w_addr_next;
        end
      end

      // Stores are committed, so a flush does not interrupt them
      ST_WRITE: begin
        if (w_cnt_inc == r_len) begin
          w_state_nxt    = ST_IDLE;
          w_ls_ready_nxt = 1'b1;
          w_ls_rdata_nxt = 32'd0;
        end else begin
          w_cnt_nxt      = w_cnt_inc;
          w_mem_a_nxt    = w_addr_next;
          w_mem_dout_nxt = w_wbyte_next;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_len        <= 3'd0;
      r_op         <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_buf        <= 32'd0;
      r_is_ls      <= 1'b0;
      r_mem_a      <= 32'd0;
      r_mem_dout   <= 8'd0;
      r_if_data    <= 32'd0;
      r_ls_rdata   <= 32'd0;
      r_if_accept  <= 1'b0;
      r_ls_accept  <= 1'b0;
      r_if_ready   <= 1'b0;
      r_ls_ready   <= 1'b0;
      r_ls_is_load <= 1'b0;
    end else if (rdy_in) begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_len        <= w_len_nxt;
      r_op         <= w_op_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_buf        <= w_buf_nxt;
      r_is_ls      <= w_is_ls_nxt;
      r_mem_a      <= w_mem_a_nxt;
      r_mem_dout   <= w_mem_dout_nxt;
      r_if_data    <= w_if_data_nxt;
      r_ls_rdata   <= w_ls_rdata_nxt;
      r_if_accept  <= w_if_accept_nxt;
      r_ls_accept  <= w_ls_accept_nxt;
      r_if_ready   <= w_if_ready_nxt;
      r_ls_ready   <= w_ls_ready_nxt;
      r_ls_is_load <= w_ls_is_load_nxt;
    end
  end

  assign bus.mem_wr     = (r_state == ST_WRITE) & rdy_in;
  assign bus.mem_a      = r_mem_a;
  assign bus.mem_dout   = r_mem_dout;
  assign bus.if_accept  = r_if_accept;
  assign bus.if_ready   = r_if_ready;
  assign bus.if_data    = r_if_data;
  assign bus.ls_accept  = r_ls_accept;
  assign bus.ls_ready   = r_ls_ready;
  assign bus.ls_is_load = r_ls_is_load;
  assign bus.ls_rdata   = r_ls_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_ctrl
//  Description : Directed self-checking bench for mem_arbiter_ctrl with a
//                byte RAM model answering one cycle after each address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_ctrl;

  logic clk_in = 1'b0;
  logic rst_n_in, rdy_in, rob_clear_up;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_wr     = 0;

  mem_arbiter_ctrl_if bus ();

  mem_arbiter_ctrl dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .rob_clear_up (rob_clear_up),
    .bus          (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [int unsigned];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk_in) begin
    bus.mem_din <= ram_rd(bus.mem_a);
    if (bus.mem_wr === 1'b1) begin
      ram[bus.mem_a] = bus.mem_dout;
      n_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_a"}, bus.mem_a, 32'd0);
    check({tag, "_if_data"}, bus.if_data, 32'd0);
    check({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
    check({tag, "_flags"}, {17'd0, bus.mem_dout, bus.mem_wr, bus.if_accept, bus.if_ready,
                            bus.ls_accept, bus.ls_ready, bus.ls_is_load}, 32'd0);
  endtask

  task automatic ls_issue(input logic we, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d);
    bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_op = op; bus.ls_addr = a; bus.ls_wdata = d;
  endtask

  // Dual request: byte load at 0x200 against a fetch at 0x100
  task automatic dual_load(input string tag, input logic [2:0] op, input logic [31:0] exp);
    ls_issue(1'b0, op, 32'h200, 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    check({tag, "_ls_acc"}, {31'd0, bus.ls_accept}, 32'd1);
    check({tag, "_if_acc"}, {31'd0, bus.if_accept}, 32'd0);
    bus.ls_req = 1'b0;
    tick();
    check({tag, "_rdy_c1"}, {31'd0, bus.ls_ready}, 32'd0);
    tick();
    check({tag, "_rdy_c2"}, {31'd0, bus.ls_ready}, 32'd1);
    check({tag, "_isload"}, {31'd0, bus.ls_is_load}, 32'd1);
    check({tag, "_rdata"}, bus.ls_rdata, exp);
    tick();
    check({tag, "_if_acc2"}, {31'd0, bus.if_accept}, 32'd1);
    bus.if_req = 1'b0;
    repeat (5) tick();
    check({tag, "_if_rdy"}, {31'd0, bus.if_ready}, 32'd1);
    check({tag, "_if_data"}, bus.if_data, 32'h0000_0513);
  endtask

  initial begin : main
    int wr0;
    int pulses;
    bit seen;
    logic [31:0] grants;
    int  n_grants;

    rst_n_in = 1'b0; rdy_in = 1'b1; rob_clear_up = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_op = 3'd0;
    bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h80;

    #22;
    check_all_zero("reset");
    tick();
    rst_n_in = 1'b1;
    tick();

    // Fetch of 0x100
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    check("t1_accept", {31'd0, bus.if_accept}, 32'd1);
    check("t1_a0", bus.mem_a, 32'h100);
    bus.if_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("t1_addr", bus.mem_a, 32'h100 + k);
    end
    tick();
    check("t1_rdy_c4", {31'd0, bus.if_ready}, 32'd0);
    tick();
    check("t1_rdy_c5", {31'd0, bus.if_ready}, 32'd1);
    check("t1_data", bus.if_data, 32'h0000_0513);
    tick();

    dual_load("t2_lb", 3'd0, 32'hFFFF_FF80);
    tick();
    dual_load("t2_lbu", 3'd4, 32'h0000_0080);
    tick();

    // SH at 0x1FE
    wr0 = n_wr;
    ls_issue(1'b1, 3'd1, 32'h1FE, 32'hABCD_1234);
    tick();
    check("t3_acc", {31'd0, bus.ls_accept}, 32'd1);
    check("t3_wr0", {31'd0, bus.mem_wr}, 32'd1);
    check("t3_a0", bus.mem_a, 32'h1FE);
    check("t3_d0", {24'd0, bus.mem_dout}, 32'h34);
    bus.ls_req = 1'b0;
    tick();
    check("t3_wr1", {31'd0, bus.mem_wr}, 32'd1);
    check("t3_a1", bus.mem_a, 32'h1FF);
    check("t3_d1", {24'd0, bus.mem_dout}, 32'h12);
    tick();
    check("t3_rdy", {31'd0, bus.ls_ready}, 32'd1);
    check("t3_isload", {31'd0, bus.ls_is_load}, 32'd0);
    check("t3_wr2", {31'd0, bus.mem_wr}, 32'd0);
    tick();
    check("t3_wr3", {31'd0, bus.mem_wr}, 32'd0);
    check("t3_nwr", n_wr - wr0, 32'd2);

    // rdy_in low freezes a byte store mid-flight
    ls_issue(1'b1, 3'd0, 32'h500, 32'h77);
    tick();
    bus.ls_req = 1'b0;
    check("frz_wr_c0", {31'd0, bus.mem_wr}, 32'd1);
    rdy_in = 1'b0;
    #1;
    check("frz_wr_low", {31'd0, bus.mem_wr}, 32'd0);
    tick();
    check("frz_hold_rdy", {31'd0, bus.ls_ready}, 32'd0);
    check("frz_hold_a", bus.mem_a, 32'h500);
    rdy_in = 1'b1;
    #1;
    check("frz_wr_back", {31'd0, bus.mem_wr}, 32'd1);
    tick();
    check("frz_done", {31'd0, bus.ls_ready}, 32'd1);
    tick();

    // SB to IO space with the IO buffer full for three cycles
    wr0 = n_wr;
    bus.io_buffer_full = 1'b1;
    ls_issue(1'b1, 3'd0, 32'h0003_0000, 32'h41);
    tick();
    check("t4_acc", {31'd0, bus.ls_accept}, 32'd1);
    check("t4_wr_c0", {31'd0, bus.mem_wr}, 32'd0);
    bus.ls_req = 1'b0;
    tick();
    check("t4_wr_c1", {31'd0, bus.mem_wr}, 32'd0);
    tick();
    check("t4_wr_c2", {31'd0, bus.mem_wr}, 32'd0);
    bus.io_buffer_full = 1'b0;
    tick();
    check("t4_wr_c3", {31'd0, bus.mem_wr}, 32'd1);
    check("t4_a", bus.mem_a, 32'h0003_0000);
    check("t4_d", {24'd0, bus.mem_dout}, 32'h41);
    check("t4_rdy_c3", {31'd0, bus.ls_ready}, 32'd0);
    tick();
    check("t4_rdy_c4", {31'd0, bus.ls_ready}, 32'd1);
    check("t4_wr_c4", {31'd0, bus.mem_wr}, 32'd0);
    tick();
    check("t4_nwr", n_wr - wr0, 32'd1);

    // LW aborted by a flush in cycle 2; a fetch raised during a flush waits
    ls_issue(1'b0, 3'd2, 32'h100, 32'd0);
    tick();
    bus.ls_req = 1'b0;
    tick();
    tick();
    rob_clear_up = 1'b1;
    tick();
    check("t5_rdy_c3", {31'd0, bus.ls_ready}, 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    check("t5_no_grant", {31'd0, bus.if_accept}, 32'd0);
    check("t5_rdy_c4", {31'd0, bus.ls_ready}, 32'd0);
    rob_clear_up = 1'b0;
    tick();
    check("t5_grant", {31'd0, bus.if_accept}, 32'd1);
    check("t5_rdy_c5", {31'd0, bus.ls_ready}, 32'd0);
    bus.if_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = bus.if_ready;
    end
    check("t5_if_rdy", {31'd0, seen}, 32'd1);
    check("t5_if_data", bus.if_data, 32'h0000_0513);
    tick();

    // SW survives a flush in cycle 1
    wr0 = n_wr;
    ls_issue(1'b1, 3'd2, 32'h300, 32'hDEAD_BEEF);
    tick();
    check("t5s_wr_c0", {31'd0, bus.mem_wr}, 32'd1);
    bus.ls_req = 1'b0;
    tick();
    rob_clear_up = 1'b1;
    tick();
    rob_clear_up = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ls_ready) pulses++;
      tick();
    end
    check("t5s_pulses", pulses, 32'd1);
    check("t5s_nwr", n_wr - wr0, 32'd4);
    check("t5s_ram", {ram_rd(32'h303), ram_rd(32'h302), ram_rd(32'h301), ram_rd(32'h300)},
          32'hDEAD_BEEF);

    // Asynchronous reset in the middle of a write
    ls_issue(1'b1, 3'd2, 32'h400, 32'h1122_3344);
    tick();
    bus.ls_req = 1'b0;
    tick();
    check("t6_wr_pre", {31'd0, bus.mem_wr}, 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_all_zero("t6");
    tick();
    rst_n_in = 1'b1;
    tick();

    // Continuous dual requests: record the first four grants (1 = LSB)
    ls_issue(1'b0, 3'd0, 32'h200, 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    grants = 32'd0;
    n_grants = 0;
    for (int i = 0; i < 60 && n_grants < 4; i++) begin
      tick();
      if (bus.ls_accept) begin grants[n_grants] = 1'b1; n_grants++; end
      else if (bus.if_accept) begin grants[n_grants] = 1'b0; n_grants++; end
    end
    bus.ls_req = 1'b0; bus.if_req = 1'b0;
    check("arb_count", n_grants, 32'd4);
`ifdef MEM_ARB_RR_EN
    check("arb_order", grants, 32'b0101);
`else
    check("arb_order", grants, 32'b1111);
`endif
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
